// File: rtl/fcache_pkg.sv
// Shared types and default geometry for the direct-mapped line cache.
// State encoding plus the default widths the cache and its tag array derive from.
package fcache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    WMEM = 2'd2
  } state_t;

  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_LINE_W  = 256;
  localparam int DEF_INDEX_W = 6;
  localparam int DEF_CNT_W   = 16;
  localparam int DEF_TAG_W   = DEF_ADDR_W - DEF_INDEX_W;
  localparam int DEF_LINES   = 1 << DEF_INDEX_W;

endpackage

// File: rtl/fcache_dm_if.sv
// Request-side and memory-side bundle of the line cache.
// slave is the cache's view; master is the view of the requester plus backing memory.
interface fcache_dm_if #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 256,
  parameter int CNT_W  = 16
);
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [LINE_W-1:0] wData;
  logic [LINE_W-1:0] rData;
  logic              ready;
  logic              hit;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wData;
  logic [LINE_W-1:0] mem_rData;
  logic              mem_ack;
  logic [CNT_W-1:0]  hit_count;
  logic [CNT_W-1:0]  miss_count;

  modport slave (
    input  read, write, addr, wData, mem_rData, mem_ack,
    output rData, ready, hit, mem_req, mem_we, mem_addr, mem_wData,
           hit_count, miss_count
  );

  modport master (
    output read, write, addr, wData, mem_rData, mem_ack,
    input  rData, ready, hit, mem_req, mem_we, mem_addr, mem_wData,
           hit_count, miss_count
  );
endinterface

// File: rtl/fcache_tag_array.sv
// Valid bits (async clear) and tag RAM with a combinational hit lookup.
// One write port; lookup and write may target different indices in the same cycle.
module fcache_tag_array
  import fcache_pkg::*;
#(
  parameter int INDEX_W = DEF_INDEX_W,
  parameter int TAG_W   = DEF_TAG_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INDEX_W-1:0] lk_index,
  input  logic [TAG_W-1:0]   lk_tag,
  output logic               lk_hit,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag
);
  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags [LINES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_index] <= 1'b1;
    end
  end

  // Tag storage is deliberately not reset; the valid bits gate every lookup.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_index] <= wr_tag;
    end
  end

  assign lk_hit = valid[lk_index] && (tags[lk_index] == lk_tag);

endmodule

// File: rtl/fcache_dm.sv
// Direct-mapped, write-through, write-allocate line cache with saturating hit/miss counters.
// Read hits return next cycle; misses and writes hold ready low until the memory acks.
module fcache_dm
  import fcache_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int LINE_W  = DEF_LINE_W,
  parameter int INDEX_W = DEF_INDEX_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic           clk,
  input  logic           reset,
  fcache_dm_if.slave     bus
);
  localparam int TAG_W = ADDR_W - INDEX_W;
  localparam int LINES = 1 << INDEX_W;

  state_t            state;
  state_t            state_nxt;
  logic [LINE_W-1:0] lines [LINES];

  logic [INDEX_W-1:0] req_index;
  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] mem_index;
  logic [TAG_W-1:0]   mem_tag;
  logic               lk_hit;
  logic               acc_wr;
  logic               acc_rd;
  logic               fill_done;
  logic               tag_wr_en;
  logic [INDEX_W-1:0] tag_wr_index;
  logic [TAG_W-1:0]   tag_wr_tag;

  assign req_index = bus.addr[INDEX_W-1:0];
  assign req_tag   = bus.addr[ADDR_W-1:INDEX_W];
  assign mem_index = bus.mem_addr[INDEX_W-1:0];
  assign mem_tag   = bus.mem_addr[ADDR_W-1:INDEX_W];

  // A write wins over a simultaneous read; the read is dropped, not queued.
  assign acc_wr    = (state == IDLE) && bus.write;
  assign acc_rd    = (state == IDLE) && bus.read && !bus.write;
  assign fill_done = (state == FILL) && bus.mem_ack;

  assign tag_wr_en    = acc_wr || fill_done;
  assign tag_wr_index = acc_wr ? req_index : mem_index;
  assign tag_wr_tag   = acc_wr ? req_tag   : mem_tag;

  fcache_tag_array #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_tags (
    .clk      (clk),
    .reset    (reset),
    .lk_index (req_index),
    .lk_tag   (req_tag),
    .lk_hit   (lk_hit),
    .wr_en    (tag_wr_en),
    .wr_index (tag_wr_index),
    .wr_tag   (tag_wr_tag)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (acc_wr) begin
          state_nxt = WMEM;
        end else if (acc_rd && !lk_hit) begin
          state_nxt = FILL;
        end
      end
      FILL:    if (bus.mem_ack) state_nxt = IDLE;
      WMEM:    if (bus.mem_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs follow the state directly, so reset drops mem_req immediately.
  always_comb begin
    bus.ready   = 1'b0;
    bus.mem_req = 1'b0;
    bus.mem_we  = 1'b0;
    case (state)
      IDLE:    bus.ready = 1'b1;
      FILL:    bus.mem_req = 1'b1;
      WMEM: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = 1'b1;
      end
      default: bus.ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (acc_wr) begin
      lines[req_index] <= bus.wData;
    end else if (fill_done) begin
      lines[mem_index] <= bus.mem_rData;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.rData     <= '0;
      bus.hit       <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wData <= '0;
    end else begin
      bus.hit <= acc_rd && lk_hit;
      if (acc_rd && lk_hit) begin
        bus.rData <= lines[req_index];
      end else if (fill_done) begin
        bus.rData <= bus.mem_rData;
      end
      if (acc_wr) begin
        bus.mem_addr  <= bus.addr;
        bus.mem_wData <= bus.wData;
      end else if (acc_rd && !lk_hit) begin
        bus.mem_addr <= bus.addr;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.hit_count  <= '0;
      bus.miss_count <= '0;
    end else begin
      if (acc_rd && lk_hit && (bus.hit_count != {CNT_W{1'b1}})) begin
        bus.hit_count <= bus.hit_count + 1'b1;
      end
      if (acc_rd && !lk_hit && (bus.miss_count != {CNT_W{1'b1}})) begin
        bus.miss_count <= bus.miss_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fcache_dm.sv
// Directed bench for fcache_dm: fills, hits, eviction, write-through, reset mid-fill,
// and counter saturation on a second instance with a 2-bit counter width.
module tb_fcache_dm;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fcache_dm_if #(.ADDR_W(16), .LINE_W(256), .CNT_W(16)) bus ();
  fcache_dm_if #(.ADDR_W(16), .LINE_W(256), .CNT_W(2))  bus2 ();

  fcache_dm #(.ADDR_W(16), .LINE_W(256), .INDEX_W(6), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  fcache_dm #(.ADDR_W(16), .LINE_W(256), .INDEX_W(6), .CNT_W(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.slave)
  );

  localparam logic [255:0] PA5 = {32{8'hA5}};
  localparam logic [255:0] P11 = {32{8'h11}};
  localparam logic [255:0] P77 = {32{8'h77}};
  localparam logic [255:0] PFF = {32{8'hFF}};
  localparam logic [255:0] P3C = {32{8'h3C}};
  localparam logic [255:0] TOP = 256'd1 << 255;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    bus.read = 1'b0;  bus.write = 1'b0;  bus.addr = '0;  bus.wData = '0;
    bus.mem_rData = '0;  bus.mem_ack = 1'b0;
    bus2.read = 1'b0; bus2.write = 1'b0; bus2.addr = '0; bus2.wData = '0;
    bus2.mem_rData = '0; bus2.mem_ack = 1'b0;
    step();
    step();
    chk("rst_ready", bus.ready, 1);
    chk("rst_memreq", bus.mem_req, 0);
    chk("rst_hit", bus.hit, 0);
    chk("rst_rdata", bus.rData, 0);
    chk("rst_hitcnt", bus.hit_count, 0);
    chk("rst_misscnt", bus.miss_count, 0);
    reset = 1'b0;
    step();

    // 1: cold miss on 0x0005, fill A5
    bus.read = 1'b1; bus.addr = 16'h0005;
    step();
    bus.read = 1'b0;
    chk("t1_memreq", bus.mem_req, 1);
    chk("t1_memwe", bus.mem_we, 0);
    chk("t1_memaddr", bus.mem_addr, 16'h0005);
    chk("t1_ready", bus.ready, 0);
    chk("t1_misscnt", bus.miss_count, 1);
    bus.mem_ack = 1'b1; bus.mem_rData = PA5;
    step();
    bus.mem_ack = 1'b0; bus.mem_rData = '0;
    chk("t1_rdata", bus.rData, PA5);
    chk("t1_ready_back", bus.ready, 1);
    chk("t1_memreq_drop", bus.mem_req, 0);
    chk("t1_nohit", bus.hit, 0);

    // 2: hit on 0x0005
    bus.read = 1'b1; bus.addr = 16'h0005;
    step();
    bus.read = 1'b0;
    chk("t2_hit", bus.hit, 1);
    chk("t2_rdata", bus.rData, PA5);
    chk("t2_memreq", bus.mem_req, 0);
    chk("t2_hitcnt", bus.hit_count, 1);
    step();
    chk("t2_hit_pulse", bus.hit, 0);

    // 3: conflict miss at 0x0045 evicts 0x0005
    bus.read = 1'b1; bus.addr = 16'h0045;
    step();
    bus.read = 1'b0;
    chk("t3_memreq", bus.mem_req, 1);
    chk("t3_memaddr", bus.mem_addr, 16'h0045);
    chk("t3_rdata_hold", bus.rData, PA5);
    step();
    chk("t3_still_waiting", bus.ready, 0);
    bus.mem_ack = 1'b1; bus.mem_rData = P11;
    step();
    bus.mem_ack = 1'b0;
    chk("t3_rdata", bus.rData, P11);
    bus.read = 1'b1; bus.addr = 16'h0005;
    step();
    bus.read = 1'b0;
    chk("t3_evict_memreq", bus.mem_req, 1);
    chk("t3_misscnt", bus.miss_count, 3);
    bus.mem_ack = 1'b1; bus.mem_rData = PA5;
    step();
    bus.mem_ack = 1'b0;
    chk("t3_refill", bus.rData, PA5);

    // 4: write-through at 0x0010, then hit on it
    bus.write = 1'b1; bus.addr = 16'h0010; bus.wData = TOP;
    step();
    bus.write = 1'b0;
    chk("t4_memreq", bus.mem_req, 1);
    chk("t4_memwe", bus.mem_we, 1);
    chk("t4_memaddr", bus.mem_addr, 16'h0010);
    chk("t4_memwdata", bus.mem_wData, TOP);
    chk("t4_ready", bus.ready, 0);
    step();
    chk("t4_ready_hold", bus.ready, 0);
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    chk("t4_ready_back", bus.ready, 1);
    chk("t4_memreq_drop", bus.mem_req, 0);
    bus.read = 1'b1; bus.addr = 16'h0010;
    step();
    bus.read = 1'b0;
    chk("t4_hit", bus.hit, 1);
    chk("t4_rdata", bus.rData, TOP);
    chk("t4_nofill", bus.mem_req, 0);
    chk("t4_hitcnt", bus.hit_count, 2);

    // 5: simultaneous read and write at 0x0020 acts as a write only
    bus.read = 1'b1; bus.write = 1'b1; bus.addr = 16'h0020; bus.wData = P3C;
    step();
    bus.read = 1'b0; bus.write = 1'b0;
    chk("t5_memwe", bus.mem_we, 1);
    chk("t5_memwdata", bus.mem_wData, P3C);
    chk("t5_ready", bus.ready, 0);
    chk("t5_hitcnt", bus.hit_count, 2);
    chk("t5_misscnt", bus.miss_count, 3);
    chk("t5_nohit", bus.hit, 0);
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    chk("t5_ready_back", bus.ready, 1);
    bus.read = 1'b1; bus.addr = 16'h0020;
    step();
    bus.read = 1'b0;
    chk("t5_readback", bus.rData, P3C);
    chk("t5_hitcnt2", bus.hit_count, 3);

    // 6: reset in the middle of a fill
    bus.read = 1'b1; bus.addr = 16'h0030;
    step();
    bus.read = 1'b0;
    chk("t6_memreq", bus.mem_req, 1);
    reset = 1'b1;
    #1;
    chk("t6_rst_memreq", bus.mem_req, 0);
    chk("t6_rst_ready", bus.ready, 1);
    chk("t6_rst_rdata", bus.rData, 0);
    step();
    reset = 1'b0;
    bus.mem_ack = 1'b1; bus.mem_rData = PFF;
    step();
    bus.mem_ack = 1'b0;
    chk("t6_late_ack_rdata", bus.rData, 0);
    chk("t6_late_ack_ready", bus.ready, 1);
    bus.read = 1'b1; bus.addr = 16'h0030;
    step();
    bus.read = 1'b0;
    chk("t6_remiss", bus.mem_req, 1);
    chk("t6_misscnt", bus.miss_count, 1);
    chk("t6_hitcnt", bus.hit_count, 0);
    bus.mem_ack = 1'b1; bus.mem_rData = P77;
    step();
    bus.mem_ack = 1'b0;
    chk("t6_fill", bus.rData, P77);

    // Saturation: 2-bit counter, one miss then five back-to-back hits
    bus2.read = 1'b1; bus2.addr = 16'h0001;
    step();
    bus2.read = 1'b0;
    chk("sat_memreq", bus2.mem_req, 1);
    bus2.mem_ack = 1'b1; bus2.mem_rData = P11;
    step();
    bus2.mem_ack = 1'b0;
    bus2.read = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("sat_b2b_hit", bus2.hit, 1);
    end
    bus2.read = 1'b0;
    chk("sat_hitcnt", bus2.hit_count, 3);
    chk("sat_misscnt", bus2.miss_count, 1);
    chk("sat_rdata", bus2.rData, P11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
